// File: rtl/bcd_time_keeper.sv
// bcd_time_keeper: 24h/12h BCD time-of-day core.
// Contents: second prescaler, HH:MM:SS BCD counters, set/hold controls and 12h display mapping.
// Optional alarm, enabled by defining TIME_KEEPER_ALARM_EN.
module bcd_time_keeper #(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned CNT_W      = 27,
  parameter int unsigned ALARM_SECS = 30
) (
  input  logic       clk_100m_i,
  input  logic       reset_n_i,
  input  logic       run_i,
  input  logic       mode_12h_i,
  input  logic       set_minutes_i,
  input  logic       set_hours_i,
  input  logic       alarm_set_min_i,
  input  logic       alarm_set_hr_i,
  input  logic       alarm_arm_i,
  output logic [3:0] hours_tens_o,
  output logic [3:0] hours_units_o,
  output logic [3:0] minutes_tens_o,
  output logic [3:0] minutes_units_o,
  output logic [5:0] seconds_bin_o,
  output logic [3:0] seconds_tens_o,
  output logic [3:0] seconds_units_o,
  output logic       pm_o,
  output logic       tick_o,
  output logic       alarm_o
);

  // BCD pair increment with wrap at max. Bit 8 is the carry out.
  // Any out-of-range pair wraps to 00 without a carry.
  function automatic logic [8:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    logic [8:0] r;
    if (val[7:4] > max[7:4] || val[3:0] > 4'd9 || (val[7:4] == max[7:4] && val[3:0] > max[3:0])) begin
      r = 9'd0;
    end else if (val == max) begin
      r = {1'b1, 8'h00};
    end else if (val[3:0] == 4'd9) begin
      r = {1'b0, val[7:4] + 4'd1, 4'd0};
    end else begin
      r = {1'b0, val[7:4], val[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [CNT_W-1:0] presc_q, presc_d;
  logic             tick_q;
  logic             tick_int_s;
  logic [7:0]       s_q, s_d, m_q, m_d, h_q, h_d, h_mid_s;
  logic [8:0]       s_inc_s, m_inc_s, h_inc_s, h_set_s;
  logic [5:0]       sec_bin_q, sec_bin_d;
  logic             pm_q;
  logic [4:0]       hb_s, disp_s;

  assign tick_int_s = run_i && (presc_q == CNT_W'(TICK_DIV - 1));
  assign s_inc_s    = bcd_inc(s_q, 8'h59);
  assign m_inc_s    = bcd_inc(m_q, 8'h59);
  assign h_inc_s    = bcd_inc(h_q, 8'h23);
  assign h_set_s    = bcd_inc(h_mid_s, 8'h23);

  // Prescaler next state: minute set restarts the second, Run=0 freezes it.
  always_comb begin
    presc_d = presc_q;
    if (set_minutes_i) begin
      presc_d = '0;
    end else if (tick_int_s) begin
      presc_d = '0;
    end else if (run_i) begin
      presc_d = presc_q + CNT_W'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // Time next state: tick chain first, minute set overrides mm/ss (and drops any tick carry),
  // hour set is applied on top of the result.
  always_comb begin
    s_d     = s_q;
    m_d     = m_q;
    h_mid_s = h_q;
    if (tick_int_s) begin
      s_d = s_inc_s[7:0];
      if (s_inc_s[8]) begin
        m_d = m_inc_s[7:0];
        if (m_inc_s[8]) begin
          h_mid_s = h_inc_s[7:0];
        end else begin
          h_mid_s = h_q;
        end
      end else begin
        m_d = m_q;
      end
    end else begin
      s_d = s_q;
    end
    if (set_minutes_i) begin
      s_d     = 8'h00;
      m_d     = m_inc_s[7:0];
      h_mid_s = h_q;
    end else begin
      m_d = m_d;
    end
  end

  // Final hour value and derived registered outputs.
  always_comb begin
    h_d       = set_hours_i ? h_set_s[7:0] : h_mid_s;
    sec_bin_d = 6'({2'b00, s_d[7:4]} * 6'd10) + {2'b00, s_d[3:0]};
  end

  // Prescaler, tick and time registers.
  always_ff @(posedge clk_100m_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      s_q       <= 8'h00;
      m_q       <= 8'h00;
      h_q       <= 8'h00;
      sec_bin_q <= 6'd0;
      pm_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_int_s;
      s_q       <= s_d;
      m_q       <= m_d;
      h_q       <= h_d;
      sec_bin_q <= sec_bin_d;
      pm_q      <= (h_d >= 8'h12);
    end
  end

  // Display hours: 12h mapping is combinational so a mode change shows immediately.
  always_comb begin
    hb_s = 5'({1'b0, h_q[7:4]} * 5'd10) + {1'b0, h_q[3:0]};
    if (hb_s == 5'd0) begin
      disp_s = 5'd12;
    end else if (hb_s > 5'd12) begin
      disp_s = hb_s - 5'd12;
    end else begin
      disp_s = hb_s;
    end
    if (mode_12h_i) begin
      if (disp_s >= 5'd10) begin
        hours_tens_o  = 4'd1;
        hours_units_o = 4'(disp_s - 5'd10);
      end else begin
        hours_tens_o  = 4'd0;
        hours_units_o = disp_s[3:0];
      end
    end else begin
      hours_tens_o  = h_q[7:4];
      hours_units_o = h_q[3:0];
    end
  end

  assign minutes_tens_o  = m_q[7:4];
  assign minutes_units_o = m_q[3:0];
  assign seconds_tens_o  = s_q[7:4];
  assign seconds_units_o = s_q[3:0];
  assign seconds_bin_o   = sec_bin_q;
  assign pm_o            = pm_q;
  assign tick_o          = tick_q;

`ifdef TIME_KEEPER_ALARM_EN
  logic [7:0] al_h_q, al_m_q;
  logic [8:0] al_h_inc_s, al_m_inc_s;
  logic [5:0] al_cnt_q;
  logic       alarm_q;
  logic       match_s;

  assign al_m_inc_s = bcd_inc(al_m_q, 8'h59);
  assign al_h_inc_s = bcd_inc(al_h_q, 8'h23);
  assign match_s    = tick_int_s && (h_d == al_h_q) && (m_d == al_m_q) && (s_d == 8'h00);

  // Alarm time registers and active-alarm countdown in ticks.
  always_ff @(posedge clk_100m_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      al_h_q   <= 8'h00;
      al_m_q   <= 8'h00;
      al_cnt_q <= 6'd0;
      alarm_q  <= 1'b0;
    end else begin
      if (alarm_set_min_i) begin
        al_m_q <= al_m_inc_s[7:0];
      end else begin
        al_m_q <= al_m_q;
      end
      if (alarm_set_hr_i) begin
        al_h_q <= al_h_inc_s[7:0];
      end else begin
        al_h_q <= al_h_q;
      end
      if (!alarm_arm_i) begin
        alarm_q  <= 1'b0;
        al_cnt_q <= 6'd0;
      end else if (match_s) begin
        alarm_q  <= 1'b1;
        al_cnt_q <= 6'(ALARM_SECS);
      end else if (tick_int_s && alarm_q) begin
        if (al_cnt_q <= 6'd1) begin
          alarm_q  <= 1'b0;
          al_cnt_q <= 6'd0;
        end else begin
          al_cnt_q <= al_cnt_q - 6'd1;
        end
      end else begin
        alarm_q <= alarm_q;
      end
    end
  end

  assign alarm_o = alarm_q;
`else
  logic unused_alarm_s;
  assign unused_alarm_s = ^{alarm_set_min_i, alarm_set_hr_i, alarm_arm_i};
  assign alarm_o        = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Bench for bcd_time_keeper: directed scenarios plus random stimulus.
// Reference model keeps time as seconds-of-day and alarm as minute-of-day.
module tb_bcd_time_keeper;
  localparam int TD = 4;
  localparam int AS = 3;

  logic clk = 1'b0, rst_n = 1'b1;
  logic run = 1'b0, mode = 1'b0, sm = 1'b0, sh = 1'b0, a_sm = 1'b0, a_sh = 1'b0, arm = 1'b0;
  logic [3:0] hours_tens, hours_units, minutes_tens, minutes_units, seconds_tens, seconds_units;
  logic [5:0] seconds_bin;
  logic       pm, tick, alarm;

  int checks = 0, errors = 0;
  int m_t = 0, m_pc = 0, m_am = 0, m_rem = 0;
  bit m_tick = 1'b0, m_al = 1'b0;

  bcd_time_keeper #(.TICK_DIV(TD), .CNT_W(3), .ALARM_SECS(AS)) dut (
    .clk_100m_i(clk), .reset_n_i(rst_n), .run_i(run), .mode_12h_i(mode),
    .set_minutes_i(sm), .set_hours_i(sh), .alarm_set_min_i(a_sm), .alarm_set_hr_i(a_sh),
    .alarm_arm_i(arm), .hours_tens_o(hours_tens), .hours_units_o(hours_units),
    .minutes_tens_o(minutes_tens), .minutes_units_o(minutes_units), .seconds_bin_o(seconds_bin),
    .seconds_tens_o(seconds_tens), .seconds_units_o(seconds_units), .pm_o(pm),
    .tick_o(tick), .alarm_o(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int hh, mm, ss, dh;
    hh = m_t / 3600; mm = (m_t / 60) % 60; ss = m_t % 60;
    dh = mode ? ((hh % 12 == 0) ? 12 : hh % 12) : hh;
    chk("hours_tens", hours_tens, dh / 10);
    chk("hours_units", hours_units, dh % 10);
    chk("minutes_tens", minutes_tens, mm / 10);
    chk("minutes_units", minutes_units, mm % 10);
    chk("seconds_tens", seconds_tens, ss / 10);
    chk("seconds_units", seconds_units, ss % 10);
    chk("seconds_bin", seconds_bin, ss);
    chk("pm", pm, (hh >= 12) ? 1 : 0);
    chk("tick", tick, m_tick);
`ifdef TIME_KEEPER_ALARM_EN
    chk("alarm", alarm, m_al);
`else
    chk("alarm", alarm, 0);
`endif
  endtask

  task automatic model_reset();
    m_t = 0; m_pc = 0; m_am = 0; m_rem = 0; m_tick = 1'b0; m_al = 1'b0;
  endtask

  // One clock with the currently driven inputs; model advances, then outputs are checked.
  task automatic step();
    int ohh, omm, nt, old_am;
    bit tk;
    @(posedge clk);
    tk = run && (m_pc == TD - 1);
    if (sm) m_pc = 0;
    else if (run) m_pc = tk ? 0 : m_pc + 1;
    ohh = m_t / 3600; omm = (m_t / 60) % 60;
    nt = m_t;
    if (tk) nt = (nt + 1) % 86400;
    if (sm) nt = ohh * 3600 + ((omm + 1) % 60) * 60;
    if (sh) nt = ((nt / 3600 + 1) % 24) * 3600 + nt % 3600;
`ifdef TIME_KEEPER_ALARM_EN
    old_am = m_am;
    if (a_sm) m_am = (m_am / 60) * 60 + (m_am % 60 + 1) % 60;
    if (a_sh) m_am = ((m_am / 60 + 1) % 24) * 60 + m_am % 60;
    if (!arm) begin m_al = 1'b0; m_rem = 0; end
    else if (tk && nt == old_am * 60) begin m_al = 1'b1; m_rem = AS; end
    else if (tk && m_al) begin
      if (m_rem <= 1) begin m_al = 1'b0; m_rem = 0; end
      else m_rem = m_rem - 1;
    end
`else
    old_am = 0;
`endif
    m_t = nt; m_tick = tk;
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    run = 0; sm = 0; sh = 0; a_sm = 0; a_sh = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic goto_time(input int h, input int m, input int s);
    apply_reset();
    sh = 1; repeat (h) step(); sh = 0;
    sm = 1; repeat (m) step(); sm = 0;
    run = 1; repeat (s * TD) step();
  endtask

  task automatic run_until_tick(output int n);
    n = 0;
    run = 1;
    do begin step(); n++; end while (tick !== 1'b1 && n < 20);
  endtask

  task automatic set_alarm(input int h, input int m);
    run = 0;
    a_sh = 1; repeat (h) step(); a_sh = 0;
    a_sm = 1; repeat (m) step(); a_sm = 0;
  endtask

  initial begin
    int n, first;
    int hrs[4]  = '{0, 12, 13, 23};
    int disp[4] = '{12, 12, 1, 11};
    int pms[4]  = '{0, 1, 1, 1};
    #2;
    apply_reset();

    // First tick after reset release arrives on the 4th cycle.
    run = 1; first = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (tick === 1'b1 && first == 0) first = i;
    end
    chk("first_tick_cycle", first, 4);

    // Reset asserted mid-count clears outputs immediately.
    repeat (5) step();
    rst_n = 1'b0; model_reset();
    #1;
    chk("rst_seconds_bin", seconds_bin, 0);
    chk("rst_tick", tick, 0);
    chk("rst_minutes_units", minutes_units, 0);
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_until_tick(n);
    chk("tick_after_release", n, 4);

    // Day rollover 23:59:58 -> 23:59:59 -> 00:00:00.
    goto_time(23, 59, 58);
    repeat (TD) step();
    chk("roll_pm_before", pm, 1);
    chk("roll_secbin_59", seconds_bin, 59);
    repeat (TD) step();
    chk("roll_pm_after", pm, 0);
    chk("roll_secbin_0", seconds_bin, 0);
    chk("roll_hours_units", hours_units, 0);

    // Hold at 10:15:07 with two prescaler counts already taken.
    goto_time(10, 15, 7);
    repeat (2) step();
    run = 0;
    repeat (20) step();
    chk("hold_seconds_units", seconds_units, 7);
    run_until_tick(n);
    chk("resume_latency", n, 2);

    // Minute set coinciding with a tick at 00:59:42.
    goto_time(0, 59, 42);
    while (m_pc != TD - 1) step();
    sm = 1; step(); sm = 0;
    chk("setmin_minutes_tens", minutes_tens, 0);
    chk("setmin_seconds_bin", seconds_bin, 0);
    chk("setmin_hours_units", hours_units, 0);

    // 12h display sweep.
    apply_reset();
    mode = 1; #1;
    for (int k = 0; k < 4; k++) begin
      sh = 1;
      for (int g = 0; g < 24 && (m_t / 3600) != hrs[k]; g++) step();
      sh = 0;
      chk("disp12_hours", hours_tens * 10 + hours_units, disp[k]);
      chk("disp12_pm", pm, pms[k]);
    end
    mode = 0; #1;
    check_all();

`ifdef TIME_KEEPER_ALARM_EN
    // Alarm at 07:30, fires on the tick into 07:30:00 and lasts AS ticks.
    goto_time(7, 29, 59);
    arm = 1;
    set_alarm(7, 30);
    run_until_tick(n);
    chk("alarm_fire", alarm, 1);
    repeat (AS * TD) step();
    chk("alarm_expired", alarm, 0);
    // Disarm while active clears on the next clock.
    goto_time(7, 29, 59);
    set_alarm(7, 30);
    run_until_tick(n);
    chk("alarm_fire2", alarm, 1);
    repeat (3) step();
    arm = 0; step();
    chk("alarm_disarm", alarm, 0);
`endif

    // Random stimulus against the model.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      run  = ($urandom_range(0, 7) != 0);
      mode = $urandom_range(0, 1);
      sm   = ($urandom_range(0, 9) == 0);
      sh   = ($urandom_range(0, 5) == 0);
      a_sm = ($urandom_range(0, 3) == 0);
      a_sh = ($urandom_range(0, 3) == 0);
      arm  = ($urandom_range(0, 15) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
